// File: rtl/lzx_coin_in.sv
// Coin acceptor front end: synchronizes and debounces two coin sensors, then queues coin events for the vending FSM.
// Optional macro LZX_COIN_INHIBIT_EN adds an inhibit input that rejects every new coin event.
module lzx_coin_in #(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_half_raw,
  input  logic                          coin_one_raw,
`ifdef LZX_COIN_INHIBIT_EN
  input  logic                          inhibit,
`endif
  input  logic                          dn_ready,
  output logic [1:0]                    coin_out,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  // Channel index 0 = half coin, 1 = one coin
  logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_d;
  logic [3:0]    r_cnt [2];
  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_fcnt;
  logic [1:0]    r_coin;
  logic          r_reject;

  logic [1:0]    w_rise;
  logic          w_inhibit;
  logic [CW-1:0] w_free;
  logic          w_acc_half, w_acc_one, w_drop, w_pop;
  logic [1:0]    w_npush, w_code0, w_head;

`ifdef LZX_COIN_INHIBIT_EN
  assign w_inhibit = inhibit;
`else
  assign w_inhibit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= {coin_one_raw, coin_half_raw};
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_d;
  assign w_free = DEPTH_C - r_fcnt;

  // Space is judged on occupancy before this cycle's pop; an empty queue
  // forwards the freshly pushed head so the coin leaves on the push edge.
  always_comb begin
    w_acc_half = w_rise[0] & ~w_inhibit & (w_free != '0);
    w_acc_one  = w_rise[1] & ~w_inhibit & (w_free > CW'(w_acc_half));
    w_drop     = (w_rise[0] & ~w_acc_half) | (w_rise[1] & ~w_acc_one);
    w_npush    = 2'(w_acc_half) + 2'(w_acc_one);
    w_code0    = w_acc_half ? 2'd1 : 2'd2;
    w_head     = (r_fcnt != '0) ? r_mem[r_rd] : w_code0;
    w_pop      = dn_ready & ((r_fcnt != '0) | (w_npush != 2'd0));
  end

  always_ff @(posedge clk) begin
    if (w_acc_half) r_mem[r_wr] <= 2'd1;
    if (w_acc_one)  r_mem[r_wr + AW'(w_acc_half)] <= 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_fcnt   <= '0;
      r_coin   <= 2'b00;
      r_reject <= 1'b0;
    end else begin
      r_wr     <= r_wr + AW'(w_npush);
      r_rd     <= r_rd + AW'(w_pop);
      r_fcnt   <= r_fcnt + CW'(w_npush) - CW'(w_pop);
      r_coin   <= w_pop ? w_head : 2'b00;
      r_reject <= w_drop;
    end
  end

  assign coin_out = r_coin;
  assign reject   = r_reject;
  assign fifo_cnt = r_fcnt;

endmodule
